// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath.
// Provides clog2 for counter widths and default pipeline sizes.
package cnn_pkg;

    localparam int PIPE_WIDTH_DEF = 8;
    localparam int PIPE_DEPTH_DEF = 3;

    // Ceiling log2, clamped to at least 1 so a width built from it is legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register.
// Ports: clk, rst, flush; up_valid/up_data from upstream;
//        dn_ready from downstream; v/data state; rdy to upstream.
module pipe_stage
    import cnn_pkg::*;
#(
    parameter int               WIDTH    = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An empty stage can always take a word, even while downstream stalls.
    assign rdy = ~v_q | dn_ready;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy) begin
            v_d = up_valid;
            // Bubbles do not overwrite data; the last real sample stays visible.
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= RST_DATA;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v    = v_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse and flush.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//        taps (stage k at [k*WIDTH +: WIDTH]), tap_valid, occupancy.
module pipe_reg_chain
    import cnn_pkg::*;
#(
    parameter int               WIDTH    = PIPE_WIDTH_DEF,
    parameter int               DEPTH    = PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [DEPTH*WIDTH-1:0]     taps,
    output logic [DEPTH-1:0]           tap_valid,
    output logic [clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int OCC_W = clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_vec;
    logic [WIDTH-1:0] d_arr [DEPTH];

    // Each stage owns its own ready net so the ripple chain is not one
    // self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_st
        logic             rdy;
        logic             dn_rdy;
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (k == DEPTH - 1) begin : g_last
            assign dn_rdy = out_ready;
        end else begin : g_mid
            assign dn_rdy = g_st[k+1].rdy;
        end

        if (k == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_inner
            assign up_v = v_vec[k-1];
            assign up_d = d_arr[k-1];
        end

        pipe_stage #(
            .WIDTH    (WIDTH),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_rdy),
            .v        (v_vec[k]),
            .data     (d_arr[k]),
            .rdy      (rdy)
        );

        assign taps[k*WIDTH +: WIDTH] = d_arr[k];
    end

    // Flush blocks both ends so nothing is handed over in that cycle.
    assign in_ready  = g_st[0].rdy & ~flush;
    assign out_valid = v_vec[DEPTH-1] & ~flush;
    assign out_data  = d_arr[DEPTH-1];
    assign tap_valid = v_vec;

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(v_vec[k]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain, WIDTH=8 DEPTH=3 RST_DATA=A5.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [23:0] taps;
    logic [2:0]  tap_valid;
    logic [1:0]  occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH    (8),
        .DEPTH    (3),
        .RST_DATA (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .taps      (taps),
        .tap_valid (tap_valid),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] bp [4];
        int idx;
        int k;
        bp[0] = 8'h11;
        bp[1] = 8'h22;
        bp[2] = 8'h33;
        bp[3] = 8'h44;

        // reset / idle
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        tick();
        check("rst_taps", 32'(taps), 24'hA5A5A5);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_tap_valid", 32'(tap_valid), 0);
        check("rst_out_data", 32'(out_data), 8'hA5);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);

        // streaming 01..0A with out_ready high
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data  = 8'(c + 1);
            #1;
            check("str_in_ready", 32'(in_ready), 1);
            check("str_out_valid", 32'(out_valid), 32'(c >= 3 && c < 13));
            if (c >= 3 && c < 13) begin
                check("str_out_data", 32'(out_data), 32'(c - 2));
            end
            tick();
        end

        // backpressure until full
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = bp[idx];
            #1;
            if (in_ready) idx++;
            tick();
        end
        in_data = bp[3];
        #1;
        check("bp_accepted", 32'(idx), 3);
        check("bp_occ", 32'(occupancy), 3);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_taps", 32'(taps), 24'h112233);
        check("bp_tap_valid", 32'(tap_valid), 3'b111);
        check("bp_out_valid", 32'(out_valid), 1);

        // release and drain in order
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 4);
            in_data  = (idx < 4) ? bp[idx & 3] : 8'h00;
            #1;
            if (out_valid) begin
                if (k < 4) check("bp_order", 32'(out_data), 32'(bp[k]));
                k++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("bp_count", 32'(k), 4);

        // bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h66;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bub_tap_valid", 32'(tap_valid), 3'b110);
        check("bub_occ", 32'(occupancy), 2);
        check("bub_taps", 32'(taps[23:8]), 16'h5566);
        check("bub_out_data", 32'(out_data), 8'h55);
        check("bub_in_ready", 32'(in_ready), 1);

        // flush with a full chain
        in_valid = 1'b1;
        in_data  = 8'h88;
        tick();
        in_valid = 1'b0;
        #1;
        check("fl_full_occ", 32'(occupancy), 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 0);
        check("fl_out_valid", 32'(out_valid), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_tap_valid", 32'(tap_valid), 0);
        check("fl_occ", 32'(occupancy), 0);
        check("fl_taps", 32'(taps), 24'h556688);
        for (int c = 0; c < 4; c++) begin
            check("fl_no_out", 32'(out_valid), 0);
            tick();
        end

        // reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        tick();
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
        #1;
        check("mr_occ", 32'(occupancy), 2);
        check("mr_tap_valid", 32'(tap_valid), 3'b011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_taps", 32'(taps), 24'hA5A5A5);
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_occ0", 32'(occupancy), 0);

        // restart after reset
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hCC;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rs_out_valid", 32'(out_valid), 1);
        check("rs_out_data", 32'(out_data), 8'hCC);
        tick();
        check("rs_empty", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
